seq_alu: RTL and testbench

- Registered, handshaked ALU, parametrised in operand width.
- Single-cycle ops: pass, add/sub, shifts, rotates, logic.
- Multi-cycle iterative MUL and DIV on one shared shift/add datapath.
- Sits between the operand-fetch stage (register file / cache read) and writeback; produces result, high/remainder word and a 32-bit flag word.

---
 rtl/seq_alu.sv | 236 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered, handshaked ALU: single-cycle ops plus iterative MUL/DIV that share
// one shift/add datapath retiring md_step bits per cycle.
module seq_alu #(
    parameter int bit_width = 32,
    parameter int md_step   = 1
) (
    input  logic                 IN_CLK,
    input  logic                 IN_RST,
    input  logic                 IN_VALID,
    output logic                 OUT_READY,
    input  logic [3:0]           IN_OP,
    input  logic [bit_width-1:0] IN_A,
    input  logic [bit_width-1:0] IN_B,
    input  logic [bit_width-1:0] IN_CACHE,
    input  logic                 IN_CARRY,
    output logic                 OUT_VALID,
    input  logic                 IN_READY,
    output logic [bit_width-1:0] OUT_R,
    output logic [bit_width-1:0] OUT_R_HI,
    output logic [31:0]          OUT_FLAG
);
    localparam int W     = bit_width;
    localparam int SW    = $clog2(W);
    localparam int ITERS = W / md_step;
    localparam int CW    = $clog2(ITERS + 1);

    localparam logic [3:0] OP_PASS_A = 4'd0,  OP_PASS_C = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3;
    localparam logic [3:0] OP_MUL    = 4'd4,  OP_DIV    = 4'd5,  OP_SHL = 4'd6,  OP_SHR = 4'd7;
    localparam logic [3:0] OP_ROL    = 4'd8,  OP_ROR    = 4'd9,  OP_NOT = 4'd10, OP_AND = 4'd11;
    localparam logic [3:0] OP_OR     = 4'd12, OP_XOR    = 4'd13;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC_MD = 2'd1, DONE = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic           is_div_q, is_div_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   r_q, r_d, r_hi_q, r_hi_d;
    logic [5:0]     flag_q, flag_d;

    // MUL: {hi,lo} holds partial product with multiplier in lo, shifted right.
    // DIV: hi is the running remainder, lo shifts dividend out and quotient in.
    function automatic logic [2*W-1:0] md_iter(input logic [W-1:0] hi, input logic [W-1:0] lo,
                                               input logic [W-1:0] m, input logic div);
        logic [W-1:0] h, l;
        logic [W:0]   x, y;
        logic [W+1:0] s;
        h = hi;
        l = lo;
        for (int i = 0; i < md_step; i++) begin
            x = div ? {h, l[W-1]} : {1'b0, h};
            y = div ? ~{1'b0, m} : (l[0] ? {1'b0, m} : '0);
            s = {1'b0, x} + {1'b0, y} + (W+2)'(div);
            if (div) begin
                h = s[W+1] ? s[W-1:0] : x[W-1:0];
                l = {l[W-2:0], s[W+1]};
            end else begin
                h = s[W:1];
                l = {s[0], l[W-1:1]};
            end
        end
        return {h, l};
    endfunction

    logic [W:0]    add_ext, sub_ext, shl_ext, shr_ext;
    logic [SW-1:0] rot_k;
    logic [SW:0]   rot_inv;
    logic [W-1:0]  rol_r, ror_r;

    assign add_ext = {1'b0, IN_A} + {1'b0, IN_B} + (W+1)'(IN_CARRY);
    assign sub_ext = {1'b0, IN_A} - {1'b0, IN_B} - (W+1)'(IN_CARRY);
    // Extra bit catches the last bit shifted out; large amounts flush to zero.
    assign shl_ext = {1'b0, IN_A} << IN_B;
    assign shr_ext = {IN_A, 1'b0} >> IN_B;
    assign rot_k   = IN_B[SW-1:0];
    assign rot_inv = (SW+1)'(W) - {1'b0, rot_k};
    assign rol_r   = (IN_A << rot_k) | (IN_A >> rot_inv);
    assign ror_r   = (IN_A >> rot_k) | (IN_A << rot_inv);

    logic [W-1:0] sc_r, sc_hi;
    logic         sc_c, sc_v, sc_dz, sc_ill;
    logic [5:0]   sc_flags;

    always_comb begin
        sc_r   = '0;
        sc_hi  = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_dz  = 1'b0;
        sc_ill = 1'b0;
        case (IN_OP)
            OP_PASS_A: sc_r = IN_A;
            OP_PASS_C: sc_r = IN_CACHE;
            OP_ADD: begin
                sc_r = add_ext[W-1:0];
                sc_c = add_ext[W];
                sc_v = (IN_A[W-1] == IN_B[W-1]) && (add_ext[W-1] != IN_A[W-1]);
            end
            OP_SUB: begin
                sc_r = sub_ext[W-1:0];
                sc_c = sub_ext[W];
                sc_v = (IN_A[W-1] != IN_B[W-1]) && (sub_ext[W-1] != IN_A[W-1]);
            end
            OP_MUL: sc_r = '0;
            OP_DIV: begin
                sc_r  = '1;
                sc_hi = IN_A;
                sc_dz = 1'b1;
            end
            OP_SHL: begin
                sc_r = shl_ext[W-1:0];
                sc_c = shl_ext[W];
            end
            OP_SHR: begin
                sc_r = shr_ext[W:1];
                sc_c = shr_ext[0];
            end
            OP_ROL: begin
                sc_r = rol_r;
                sc_c = (rot_k != '0) && rol_r[0];
            end
            OP_ROR: begin
                sc_r = ror_r;
                sc_c = (rot_k != '0) && ror_r[W-1];
            end
            OP_NOT: sc_r = ~IN_A;
            OP_AND: sc_r = IN_A & IN_B;
            OP_OR:  sc_r = IN_A | IN_B;
            OP_XOR: sc_r = IN_A ^ IN_B;
            default: sc_ill = 1'b1;
        endcase
        sc_flags = {sc_ill, sc_dz, sc_v, sc_r[W-1], sc_c, sc_r == '0};
    end

    logic [2*W-1:0] md_next;
    logic [5:0]     md_flags;
    logic           md_req, accept, md_load;

    assign md_next  = md_iter(hi_q, lo_q, m_q, is_div_q);
    assign md_flags = is_div_q ? {3'b000, lo_q[W-1], 1'b0, lo_q == '0}
                               : {2'b00, hi_q != '0, lo_q[W-1], hi_q != '0, {hi_q, lo_q} == '0};
    // Divide by zero short-circuits to the single-cycle path.
    assign md_req    = (IN_OP == OP_MUL) || ((IN_OP == OP_DIV) && (IN_B != '0));
    assign OUT_READY = (state_q == IDLE) && (!out_valid_q || IN_READY);
    assign accept    = IN_VALID && OUT_READY;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        m_d         = m_q;
        is_div_d    = is_div_q;
        out_valid_d = out_valid_q;
        r_d         = r_q;
        r_hi_d      = r_hi_q;
        flag_d      = flag_q;
        md_load     = 1'b0;
        if (out_valid_q && IN_READY)
            out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (md_req) begin
                        state_d  = EXEC_MD;
                        cnt_d    = '0;
                        is_div_d = (IN_OP == OP_DIV);
                        m_d      = (IN_OP == OP_DIV) ? IN_B : IN_A;
                        lo_d     = (IN_OP == OP_DIV) ? IN_A : IN_B;
                        hi_d     = '0;
                    end else begin
                        out_valid_d = 1'b1;
                        r_d         = sc_r;
                        r_hi_d      = sc_hi;
                        flag_d      = sc_flags;
                    end
                end
            end
            EXEC_MD: begin
                if (cnt_q != CW'(ITERS)) begin
                    {hi_d, lo_d} = md_next;
                    cnt_d        = cnt_q + CW'(1);
                end else if (!out_valid_q || IN_READY) begin
                    md_load = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (IN_READY)
                    md_load = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (md_load) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            r_d         = lo_q;
            r_hi_d      = hi_q;
            flag_d      = md_flags;
        end
    end

    always_ff @(posedge IN_CLK) begin
        if (IN_RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            m_q         <= '0;
            is_div_q    <= 1'b0;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            r_hi_q      <= '0;
            flag_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            m_q         <= m_d;
            is_div_q    <= is_div_d;
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            r_hi_q      <= r_hi_d;
            flag_q      <= flag_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT_R     = r_q;
    assign OUT_R_HI  = r_hi_q;
    assign OUT_FLAG  = {26'b0, flag_q};

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (8-bit): directed cases with literal expectations plus random
// traffic compared every cycle against a cycle-level behavioural model.
module tb_seq_alu;
    localparam int ITERS = 8;

    logic       clk, rst, in_valid, valid4, in_ready, in_carry;
    logic [3:0] in_op;
    logic [7:0] in_a, in_b, in_cache;
    logic       out_ready, out_valid, out_ready4, out_valid4;
    logic [7:0] out_r, out_hi, out_r4, out_hi4;
    logic [31:0] out_flag, out_flag4;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu #(.bit_width(8), .md_step(1)) u_dut (
        .IN_CLK(clk), .IN_RST(rst), .IN_VALID(in_valid), .OUT_READY(out_ready),
        .IN_OP(in_op), .IN_A(in_a), .IN_B(in_b), .IN_CACHE(in_cache), .IN_CARRY(in_carry),
        .OUT_VALID(out_valid), .IN_READY(in_ready), .OUT_R(out_r), .OUT_R_HI(out_hi),
        .OUT_FLAG(out_flag));

    seq_alu #(.bit_width(8), .md_step(4)) u_dut4 (
        .IN_CLK(clk), .IN_RST(rst), .IN_VALID(valid4), .OUT_READY(out_ready4),
        .IN_OP(in_op), .IN_A(in_a), .IN_B(in_b), .IN_CACHE(in_cache), .IN_CARRY(in_carry),
        .OUT_VALID(out_valid4), .IN_READY(in_ready), .OUT_R(out_r4), .OUT_R_HI(out_hi4),
        .OUT_FLAG(out_flag4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int sx(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    // Reference: result, high word, flags and latency class from the op definitions.
    function automatic void ref_op(input int op, input int a, input int b, input int cache,
                                   input int cin, output bit [7:0] r, output bit [7:0] hi,
                                   output bit [31:0] fl, output int lat);
        int x, p, ss;
        bit c, v, dz, ill, o, z;
        x = 0; p = -1; c = 0; v = 0; dz = 0; ill = 0; lat = 1; hi = 0;
        case (op)
            0: x = a;
            1: x = cache;
            2: begin
                x = a + b + cin; c = (x > 255);
                ss = sx(a) + sx(b) + cin; v = (ss > 127) || (ss < -128);
            end
            3: begin
                x = a - b - cin; c = (x < 0);
                ss = sx(a) - sx(b) - cin; v = (ss > 127) || (ss < -128);
            end
            4: begin
                p = a * b; x = p % 256; hi = 8'(p / 256); c = (hi != 0); v = c; lat = ITERS + 1;
            end
            5: begin
                if (b == 0) begin x = 255; hi = 8'(a); dz = 1; end
                else begin x = a / b; hi = 8'(a % b); lat = ITERS + 1; end
            end
            6: begin x = a; for (int i = 0; i < b; i++) begin c = x[7]; x = (x << 1) & 255; end end
            7: begin x = a; for (int i = 0; i < b; i++) begin c = x[0]; x = x >> 1; end end
            8: begin
                x = a;
                for (int i = 0; i < b % 8; i++) begin o = x[7]; x = ((x << 1) & 255) | int'(o); c = o; end
            end
            9: begin
                x = a;
                for (int i = 0; i < b % 8; i++) begin o = x[0]; x = (x >> 1) | (int'(o) << 7); c = o; end
            end
            10: x = (~a) & 255;
            11: x = a & b;
            12: x = a | b;
            13: x = a ^ b;
            default: begin x = 0; ill = 1; end
        endcase
        r  = 8'(x & 255);
        z  = (op == 4) ? (p == 0) : (r == 0);
        fl = {26'b0, ill, dz, v, r[7], c, z};
    endfunction

    int        m_busy = 0;
    bit        m_valid = 0;
    bit [7:0]  m_r = 0, m_hi = 0, p_r = 0, p_hi = 0;
    bit [31:0] m_flag = 0, p_flag = 0;

    function automatic bit m_ready();
        return (m_busy == 0) && (!m_valid || in_ready);
    endfunction

    always @(posedge clk) begin
        bit [7:0]  r, hi;
        bit [31:0] fl;
        int        lat, n_busy;
        bit        n_valid;
        if (rst) begin
            m_busy  <= 0;
            m_valid <= 0;
        end else begin
            n_busy  = m_busy;
            n_valid = m_valid;
            if (m_valid && in_ready) n_valid = 0;
            if (m_busy > 0) begin
                if (!(m_busy == 1 && n_valid)) begin
                    n_busy = m_busy - 1;
                    if (n_busy == 0) begin
                        n_valid = 1; m_r <= p_r; m_hi <= p_hi; m_flag <= p_flag;
                    end
                end
            end else if (in_valid && m_ready()) begin
                ref_op(int'(in_op), int'(in_a), int'(in_b), int'(in_cache), int'(in_carry), r, hi, fl, lat);
                if (lat == 1) begin
                    n_valid = 1; m_r <= r; m_hi <= hi; m_flag <= fl;
                end else begin
                    n_busy = lat; p_r <= r; p_hi <= hi; p_flag <= fl;
                end
            end
            m_busy  <= n_busy;
            m_valid <= n_valid;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_ready", 32'(out_ready), 32'(m_ready()));
            chk("model_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("model_r", 32'(out_r), 32'(m_r));
                chk("model_hi", 32'(out_hi), 32'(m_hi));
                chk("model_flag", out_flag, m_flag);
            end
        end
    end

    task automatic send(input int op, input int a, input int b, input int cin);
        in_op = 4'(op); in_a = 8'(a); in_b = 8'(b); in_carry = cin[0]; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!out_valid && k < 30) begin @(posedge clk); #1; k++; end
    endtask

    initial begin
        int k;
        rst = 1; in_valid = 0; valid4 = 0; in_ready = 1; in_op = 0;
        in_a = 0; in_b = 0; in_cache = 0; in_carry = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_r", 32'(out_r), 0);
        chk("rst_hi", 32'(out_hi), 0);
        chk("rst_flag", out_flag, 0);
        chk("rst_ready", 32'(out_ready), 1);

        send(2, 'hFF, 'h01, 0);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_r", 32'(out_r), 'h00);
        chk("add_flag", out_flag, 'h03);
        send(3, 'h80, 'h01, 0);
        chk("sub_r", 32'(out_r), 'h7F);
        chk("sub_flag", out_flag, 'h08);

        send(4, 'h10, 'h20, 0);
        wait_valid(k);
        chk("mul_latency", 32'(k), 9);
        chk("mul_r", 32'(out_r), 'h00);
        chk("mul_hi", 32'(out_hi), 'h02);
        chk("mul_flag", out_flag, 'h0A);

        valid4 = 1;
        @(posedge clk); #1;
        valid4 = 0;
        k = 0;
        while (!out_valid4 && k < 30) begin @(posedge clk); #1; k++; end
        chk("mul4_latency", 32'(k), 3);
        chk("mul4_hi", 32'(out_hi4), 'h02);
        chk("mul4_flag", out_flag4, 'h0A);

        send(5, 'h64, 'h07, 0);
        wait_valid(k);
        chk("div_latency", 32'(k), 9);
        chk("div_q", 32'(out_r), 'h0E);
        chk("div_rem", 32'(out_hi), 'h02);
        send(5, 'h33, 'h00, 0);
        chk("dz_valid", 32'(out_valid), 1);
        chk("dz_r", 32'(out_r), 'hFF);
        chk("dz_hi", 32'(out_hi), 'h33);
        chk("dz_flag", out_flag, 'h14);

        send(8, 'h81, 1, 0);
        chk("rol_r", 32'(out_r), 'h03);
        chk("rol_flag", out_flag, 'h02);
        send(6, 'h81, 9, 0);
        chk("shl_r", 32'(out_r), 'h00);
        chk("shl_flag", out_flag, 'h01);
        send(9, 'h01, 9, 0);
        chk("ror_r", 32'(out_r), 'h80);
        send(15, 'h12, 'h34, 0);
        chk("ill_r", 32'(out_r), 'h00);
        chk("ill_flag", out_flag, 'h21);

        @(posedge clk); #1;
        in_ready = 0;
        send(13, 'hF0, 'h3C, 0);
        chk("bp_xor", 32'(out_r), 'hCC);
        in_op = 4'd11; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_ready_low", 32'(out_ready), 0);
            chk("bp_hold", 32'(out_r), 'hCC);
        end
        in_ready = 1;
        #1 chk("bp_ready_up", 32'(out_ready), 1);
        @(posedge clk); #1;
        in_valid = 0;
        chk("bp_and_valid", 32'(out_valid), 1);
        chk("bp_and_r", 32'(out_r), 'h30);

        send(4, 'h0F, 'h0E, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_r", 32'(out_r), 0);
        chk("abort_hi", 32'(out_hi), 0);
        chk("abort_flag", out_flag, 0);
        chk("abort_ready", 32'(out_ready), 1);
        send(2, 2, 3, 0);
        chk("post_abort_add", 32'(out_r), 'h05);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            rst      = ($urandom_range(0, 399) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_op    = 4'($urandom_range(0, 15));
            in_a     = 8'($urandom);
            case ($urandom_range(0, 3))
                0: in_b = 8'($urandom_range(0, 12));
                1: in_b = 8'h00;
                default: in_b = 8'($urandom);
            endcase
            in_cache = 8'($urandom);
            in_carry = 1'($urandom_range(0, 1));
            in_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        rst = 0; in_valid = 0; in_ready = 1;
        repeat (20) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
